// File: rtl/rom_port_responder.sv
// Toggle-handshake port to level-handshake memory bridge with a sticky protocol-error flag.
// Optional feature macro: PORT_REQ_SYNC_EN (2-flop synchronizer on port_req).
module rom_port_responder #(
  parameter int AW = 23
) (
  input  logic          clk_sys,
  input  logic          res_n,
  input  logic          port_req,
  output logic          port_ack,
  input  logic [AW-1:0] port_a,
  input  logic [1:0]    port_ds,
  input  logic          port_we,
  input  logic [15:0]   port_d,
  output logic [15:0]   port_q,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_ds,
  output logic          mem_we,
  output logic [15:0]   mem_d,
  input  logic          mem_rdy,
  input  logic [15:0]   mem_q,
  output logic          busy,
  output logic          proto_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  logic   eff_req_s;
  state_t state_r, state_s;
  logic   req_seen_r, req_seen_s;
  logic   ack_s, mem_req_s, mem_we_s, busy_s, err_s;
  logic [15:0]   q_s, mem_d_s;
  logic [AW-1:0] addr_s;
  logic [1:0]    ds_s;

`ifdef PORT_REQ_SYNC_EN
  logic [1:0] req_sync_r;

  // Two-flop synchronizer for the asynchronous request toggle
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      req_sync_r <= 2'b00;
    end else begin
      req_sync_r <= {req_sync_r[0], port_req};
    end
  end

  assign eff_req_s = req_sync_r[1];
`else
  assign eff_req_s = port_req;
`endif

  // Next-state and next-output computation for the transfer FSM
  always_comb begin
    state_s    = state_r;
    req_seen_s = req_seen_r;
    ack_s      = port_ack;
    q_s        = port_q;
    mem_req_s  = mem_req;
    addr_s     = mem_addr;
    ds_s       = mem_ds;
    mem_we_s   = mem_we;
    mem_d_s    = mem_d;
    busy_s     = busy;
    // Any request change while a transfer is in flight is a violation; the transfer itself runs on.
    err_s      = proto_err | (busy & (eff_req_s != req_seen_r));
    case (state_r)
      IDLE: begin
        if (eff_req_s != req_seen_r) begin
          req_seen_s = eff_req_s;
          addr_s     = port_a;
          ds_s       = port_ds;
          mem_we_s   = port_we;
          mem_d_s    = port_d;
          busy_s     = 1'b1;
          // Only a write with no byte lanes is a no-op; reads always fetch the full word.
          if (port_we && (port_ds == 2'b00)) begin
            state_s = DONE;
          end else begin
            mem_req_s = 1'b1;
            state_s   = ACCESS;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (mem_rdy) begin
          mem_req_s = 1'b0;
          q_s       = mem_we ? port_q : mem_q;
          state_s   = DONE;
        end else begin
          state_s = ACCESS;
        end
      end
      DONE: begin
        ack_s   = req_seen_r;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        mem_req_s = 1'b0;
        busy_s    = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state_r    <= IDLE;
      req_seen_r <= 1'b0;
      port_ack   <= 1'b0;
      port_q     <= 16'h0000;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_ds     <= 2'b00;
      mem_we     <= 1'b0;
      mem_d      <= 16'h0000;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state_r    <= state_s;
      req_seen_r <= req_seen_s;
      port_ack   <= ack_s;
      port_q     <= q_s;
      mem_req    <= mem_req_s;
      mem_addr   <= addr_s;
      mem_ds     <= ds_s;
      mem_we     <= mem_we_s;
      mem_d      <= mem_d_s;
      busy       <= busy_s;
      proto_err  <= err_s;
    end
  end

endmodule
